// File: rtl/td4_ctrl_seq.sv
// td4_ctrl_seq: sequenced control unit for a TD4-class CPU.
// Owns IR, PC and carry flag; adds run/step control and undefined-op handling.
module td4_ctrl_seq #(
    parameter int unsigned DW           = 4,
    parameter int unsigned PCW          = 4,
    parameter int unsigned TRAP_ILLEGAL = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            step,
    input  logic [DW+3:0]   instr,
    input  logic            alu_carry,
    output logic [PCW-1:0]  pc,
    output logic [1:0]      sel,
    output logic [3:0]      load_n,
    output logic [DW-1:0]   imm,
    output logic            cflg,
    output logic            illegal,
    output logic            halted
);

    localparam int unsigned IW = DW + 4;
    localparam int unsigned MW = (PCW < DW) ? PCW : DW;
    localparam logic [PCW-1:0] PC_ONE = PCW'(1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic            cflg_q, cflg_d;
    logic            ill_q, ill_d;

    logic [3:0]      op;
    logic [1:0]      dec_sel;
    logic [3:0]      dec_load_n;
    logic            dec_bad;
    logic [PCW-1:0]  pc_inc;
    logic [PCW-1:0]  jmp_tgt;
    logic [1:0]      sel_o;
    logic [3:0]      load_n_o;

    assign op     = ir_q[IW-1:DW];
    assign pc_inc = pc_q + PC_ONE;

    // Jump target: IR immediate truncated or zero-extended to the PC width
    always_comb begin
        jmp_tgt = '0;
        jmp_tgt[MW-1:0] = ir_q[MW-1:0];
    end

    // Decode of the latched opcode; JNC looks at the flag before this EXEC updates it
    always_comb begin
        dec_sel    = 2'b00;
        dec_load_n = 4'b1111;
        dec_bad    = 1'b0;
        casez (op)
            4'b00??: begin
                dec_sel    = op[1:0];
                dec_load_n = 4'b1110;
            end
            4'b01??: begin
                dec_sel    = op[1:0];
                dec_load_n = 4'b1101;
            end
            4'b1001: begin
                dec_sel    = 2'b01;
                dec_load_n = 4'b1011;
            end
            4'b1011: begin
                dec_sel    = 2'b11;
                dec_load_n = 4'b1011;
            end
            4'b1111: begin
                dec_sel    = 2'b11;
                dec_load_n = 4'b0111;
            end
            4'b1110: begin
                if (!cflg_q) begin
                    dec_sel    = 2'b11;
                    dec_load_n = 4'b0111;
                end
            end
            default: begin
                dec_bad = 1'b1;
            end
        endcase
    end

    // Sequencer: next state, architectural updates and EXEC-only control outputs
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        pc_d     = pc_q;
        cflg_d   = cflg_q;
        ill_d    = ill_q;
        sel_o    = 2'b00;
        load_n_o = 4'b1111;
        case (state_q)
            S_WAIT: begin
                if (run || step) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                sel_o    = dec_sel;
                load_n_o = dec_load_n;
                state_d  = run ? S_FETCH : S_WAIT;
                if (dec_bad) begin
                    ill_d = 1'b1;
                    if (TRAP_ILLEGAL != 0) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc_inc;
                    end
                end else begin
                    cflg_d = alu_carry;
                    pc_d   = dec_load_n[3] ? pc_inc : jmp_tgt;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase
    end

    // State register; reset wins over any in-flight instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            pc_q    <= '0;
            cflg_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            cflg_q  <= cflg_d;
            ill_q   <= ill_d;
        end
    end

    assign pc      = pc_q;
    assign sel     = sel_o;
    assign load_n  = load_n_o;
    assign imm     = ir_q[DW-1:0];
    assign cflg    = cflg_q;
    assign illegal = ill_q;
    assign halted  = (state_q == S_HALT);

endmodule

// File: doc/td4_ctrl_seq.md
Name: td4_ctrl_seq

Overview:
- Parametrised, sequenced control unit for the TD4-class CPU.
- Latches the instruction into an internal IR, decodes it, and drives the source mux select and active-low load enables for exactly one EXEC cycle.
- Owns the program counter and the carry flag, and adds run/single-step control and defined handling of undefined opcodes.
- Sits between program ROM (instr at pc) and the register file/ALU datapath.

Parameters:
- DW, 4, data and immediate width; instr width is 4+DW.
- PCW, 4, program counter width; the jump target is imm truncated or zero-extended to PCW.
- TRAP_ILLEGAL, 0, 1 = an undefined opcode halts the sequencer until reset; 0 = it executes as a NOP.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  level; 1 = free run, 0 = single-step mode.
- step  in  1  in step mode, a high sample while in WAIT starts one instruction.
- instr  in  4+DW  ROM word at pc; op = instr[DW+3:DW], imm = instr[DW-1:0].
- alu_carry  in  1  adder carry-out, valid during EXEC.
- pc  out  PCW  program counter.
- sel  out  2  datapath source: 00 A, 01 B, 10 IN, 11 zero.
- load_n  out  4  active-low load enables: bit0 A, bit1 B, bit2 OUT, bit3 PC.
- imm  out  DW  registered immediate from IR.
- cflg  out  1  carry flag.
- illegal  out  1  sticky; set on the first undefined opcode.
- halted  out  1  high in HALT.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=0, load_n=1111, sel=00, imm=0, cflg=0, illegal=0, halted=0, state=WAIT.
  - Reset overrides everything, including mid-EXEC; load_n is 1111 from that edge onward.
- States: WAIT, FETCH, EXEC, HALT.
  - WAIT: if run=1 or step=1, go to FETCH; otherwise stay.
  - FETCH: IR <= instr; imm <= IR imm field; go to EXEC.
  - EXEC: drive decode outputs for exactly this one cycle. Next state is FETCH if run=1, else WAIT. A trapped illegal opcode goes to HALT.
  - HALT: all outputs frozen, load_n=1111; leaves only on reset.
- Throughput: 2 cycles per instruction in run mode.
- step is ignored outside WAIT. Deasserting run mid-instruction completes the instruction and then waits.
- load_n=1111 and sel=00 in every state except EXEC.
- Decode in EXEC (op: sel, load_n):
  - 00ss: sel=ss, load_n=1110 (A).
  - 01ss: sel=ss, load_n=1101 (B).
  - 1001: sel=01, load_n=1011 (OUT).
  - 1011: sel=11, load_n=1011 (OUT).
  - 1111: sel=11, load_n=0111 (JMP).
  - 1110 with cflg=0: sel=11, load_n=0111 (JNC taken).
  - 1110 with cflg=1: sel=00, load_n=1111 (not taken).
  - 1000, 1010, 1100, 1101: undefined; sel=00, load_n=1111, illegal<=1.
- PC update at the end of EXEC:
  - load_n[3]=0: pc <= imm (resized to PCW).
  - Otherwise pc <= pc+1 modulo 2^PCW; 2^PCW-1 wraps to 0.
  - Trapped illegal (TRAP_ILLEGAL=1): pc holds, halted<=1.
- Carry:
  - Every legal EXEC latches cflg <= alu_carry, jumps included; JNC decodes on the pre-update cflg.
  - Illegal ops leave cflg unchanged.

Test Plan:
1. Reset, run=1, instr=0x03 at pc 0 → cycle1 FETCH, cycle2 EXEC with sel=00, load_n=1110, imm=3; pc=1 after the cycle-2 edge.
2. Prior EXEC with alu_carry=1, then instr=0xE5 → EXEC load_n=1111, pc+1. Repeat with cflg=0 → sel=11, load_n=0111, pc=5.
3. instr=0x8A:
   - TRAP_ILLEGAL=0 → load_n=1111, illegal=1 (stays 1), pc+1, cflg unchanged.
   - TRAP_ILLEGAL=1 → halted=1, pc frozen, no further EXEC until rst_n=0.
4. run=0, three step pulses (one during EXEC) → exactly two EXEC cycles, pc advances by 2.
5. pc=15 (PCW=4), instr=0x40 → pc wraps to 0, load_n=1101 during EXEC.
6. rst_n=0 sampled in EXEC of 0xF7 → load_n=1111 and pc=0 at that edge, no jump to 7.
